// File: rtl/vin_pkg.sv
// Shared definitions for the video input stream FIFO: checker states and flow_result bit map.
package vin_pkg;

  localparam int unsigned ERR_W = 4;

  localparam int unsigned ERR_EARLY_EOP     = 0;
  localparam int unsigned ERR_MISSING_EOP   = 1;
  localparam int unsigned ERR_SOP_IN_FRAME  = 2;
  localparam int unsigned ERR_OUTSIDE_FRAME = 3;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } vin_state_e;

endpackage

// File: rtl/vin_sync_fifo.sv
// First-word-fall-through FIFO: head entry is visible on o_rd_data whenever o_valid is high.
module vin_sync_fifo #(
  parameter int unsigned W     = 34,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned FW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr_en,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_rd_en,
  output logic [W-1:0]  o_rd_data,
  output logic          o_valid,
  output logic [FW-1:0] o_fill,
  output logic [FW-1:0] o_fill_next
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [FW-1:0] r_fill;
  logic          w_rd;

  // A read of an empty FIFO is ignored, so a same-cycle write at fill 0 acts alone.
  assign w_rd = i_rd_en && (r_fill != '0);

  always_comb begin
    o_fill_next = r_fill;
    case ({i_wr_en, w_rd})
      2'b10:   o_fill_next = r_fill + FW'(1);
      2'b01:   o_fill_next = r_fill - FW'(1);
      default: o_fill_next = r_fill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (i_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd)    r_rd_ptr <= r_rd_ptr + 1'b1;
      r_fill <= o_fill_next;
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_valid   = (r_fill != '0);
  assign o_fill    = r_fill;

endmodule

// File: rtl/video_in_stream_fifo.sv
// Avalon-ST video input buffer with frame checker; define VIN_FRAME_CNT_EN to enable frame_count.
module video_in_stream_fifo
  import vin_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_LVL = DEPTH - 2,
  parameter int unsigned CNT_W     = 32,
  localparam int unsigned FW       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sink_data,
  input  logic              sink_valid,
  input  logic              sink_sop,
  input  logic              sink_eop,
  output logic              sink_ready,
  output logic [DATA_W-1:0] source_data,
  output logic              source_sop,
  output logic              source_eop,
  output logic              source_valid,
  input  logic              source_ready,
  input  logic [15:0]       width,
  input  logic [15:0]       height,
  input  logic              err_clear,
  output logic [ERR_W-1:0]  flow_result,
  output logic [FW-1:0]     fill_level,
  output logic              fifo_empty,
  output logic [15:0]       frame_count
);

  logic              r_sink_ready;
  logic              w_acc;
  logic [FW-1:0]     w_fill_next;
  logic [DATA_W+1:0] w_head;

  assign w_acc = sink_valid && r_sink_ready;

  vin_sync_fifo #(
    .W     (DATA_W + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_wr_en     (w_acc),
    .i_wr_data   ({sink_data, sink_sop, sink_eop}),
    .i_rd_en     (source_ready),
    .o_rd_data   (w_head),
    .o_valid     (source_valid),
    .o_fill      (fill_level),
    .o_fill_next (w_fill_next)
  );

  assign source_data = w_head[DATA_W+1:2];
  assign source_sop  = w_head[1];
  assign source_eop  = w_head[0];
  assign fifo_empty  = (fill_level == '0);

  // Registered from next fill so ready drops on the same edge fill reaches the threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sink_ready <= 1'b1;
    else     r_sink_ready <= !(w_fill_next >= FW'(AFULL_LVL));
  end
  assign sink_ready = r_sink_ready;

  vin_state_e       r_state;
  vin_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_total;
  logic             w_len_ok;
  logic [ERR_W-1:0] w_set;
  logic [ERR_W-1:0] r_flow;

  assign w_total   = CNT_W'({16'd0, width} * {16'd0, height});
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  // Length check for an eop beat: a sop+eop beat is a one-beat frame.
  assign w_len_ok  = sink_sop ? (w_total == CNT_W'(1)) : (w_cnt_inc == w_total);

  always_comb begin
    w_set       = '0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_acc) begin
      if (sink_sop) begin
        if (r_state == IN_FRAME) w_set[ERR_SOP_IN_FRAME] = 1'b1;
        if (sink_eop) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          if (!w_len_ok) w_set[ERR_EARLY_EOP] = 1'b1;
        end else if (w_total == CNT_W'(1)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_set[ERR_MISSING_EOP] = 1'b1;
        end else begin
          w_state_nxt = IN_FRAME;
          w_cnt_nxt   = CNT_W'(1);
        end
      end else if (r_state == IDLE) begin
        w_set[ERR_OUTSIDE_FRAME] = 1'b1;
      end else if (sink_eop) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        if (!w_len_ok) w_set[ERR_EARLY_EOP] = 1'b1;
      end else if (w_cnt_inc == w_total) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_set[ERR_MISSING_EOP] = 1'b1;
      end else begin
        w_cnt_nxt = w_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_flow  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_flow  <= err_clear ? '0 : (r_flow | w_set);
    end
  end
  assign flow_result = r_flow;

`ifdef VIN_FRAME_CNT_EN
  logic        w_good;
  logic [15:0] r_frame_cnt;

  assign w_good = w_acc && sink_eop && w_len_ok && (sink_sop || (r_state == IN_FRAME));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_frame_cnt <= '0;
    else if (w_good) r_frame_cnt <= r_frame_cnt + 16'd1;
  end
  assign frame_count = r_frame_cnt;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_video_in_stream_fifo.sv
// Directed self-checking bench for video_in_stream_fifo (DEPTH=16, AFULL_LVL=14).
module tb_video_in_stream_fifo;

`ifdef VIN_FRAME_CNT_EN
  localparam int FC_EN = 1;
`else
  localparam int FC_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sink_data;
  logic        sink_valid, sink_sop, sink_eop, sink_ready;
  logic [31:0] source_data;
  logic        source_sop, source_eop, source_valid, source_ready;
  logic [15:0] width, height;
  logic        err_clear;
  logic [3:0]  flow_result;
  logic [4:0]  fill_level;
  logic        fifo_empty;
  logic [15:0] frame_count;

  int checks   = 0;
  int failures = 0;
  int exp_fc   = 0;
  logic [33:0] q_out [$];

  video_in_stream_fifo #(.DATA_W(32), .DEPTH(16), .AFULL_LVL(14), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_ready(sink_ready),
    .source_data(source_data), .source_sop(source_sop), .source_eop(source_eop),
    .source_valid(source_valid), .source_ready(source_ready),
    .width(width), .height(height), .err_clear(err_clear),
    .flow_result(flow_result), .fill_level(fill_level), .fifo_empty(fifo_empty),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && source_valid && source_ready) q_out.push_back({source_data, source_sop, source_eop});

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic s, input logic e);
    bit done = 0;
    int n = 0;
    sink_data = d; sink_sop = s; sink_eop = e; sink_valid = 1'b1;
    while (!done) begin
      done = sink_ready;
      @(posedge clk); #1;
      n++;
      if (!done && n > 50) begin
        checks++; failures++;
        $display("FAIL send_timeout got=ready_low required=accept");
        done = 1;
      end
    end
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] base);
    for (int i = 0; i < 8; i++) send_beat(base + 32'(i), i == 0, i == 7);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (fill_level !== 5'd0)   begin failures++; $display("FAIL rst_fill got=%0d required=0", fill_level); end
    checks++; if (source_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b required=0", source_valid); end
    checks++; if (fifo_empty !== 1'b1)   begin failures++; $display("FAIL rst_empty got=%b required=1", fifo_empty); end
    checks++; if (sink_ready !== 1'b1)   begin failures++; $display("FAIL rst_ready got=%b required=1", sink_ready); end
    checks++; if (flow_result !== 4'd0)  begin failures++; $display("FAIL rst_flow got=%b required=0000", flow_result); end
    checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL rst_fc got=%0d required=0", frame_count); end
  endtask

  task automatic test_basic_frame();
    logic [33:0] exp;
    q_out.delete();
    source_ready = 1'b1;
    send_beat(32'hA0, 1'b1, 1'b0);
    checks++; if (source_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b required=1", source_valid); end
    checks++; if (source_data !== 32'hA0 || source_sop !== 1'b1) begin
      failures++; $display("FAIL first_head got=%h/%b required=a0/1", source_data, source_sop);
    end
    for (int i = 1; i < 8; i++) send_beat(32'hA0 + 32'(i), 1'b0, i == 7);
    idle(4);
    exp_fc += FC_EN;
    checks++; if (q_out.size() != 8) begin failures++; $display("FAIL basic_count got=%0d required=8", q_out.size()); end
    for (int i = 0; i < 8 && i < q_out.size(); i++) begin
      exp = {32'hA0 + 32'(i), i == 0, i == 7};
      checks++; if (q_out[i] !== exp) begin failures++; $display("FAIL basic_beat%0d got=%h required=%h", i, q_out[i], exp); end
    end
    checks++; if (flow_result !== 4'd0) begin failures++; $display("FAIL basic_flow got=%b required=0000", flow_result); end
    checks++; if (frame_count !== 16'(exp_fc)) begin failures++; $display("FAIL basic_fc got=%0d required=%0d", frame_count, exp_fc); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int n = 0;
    bit took;
    q_out.delete();
    source_ready = 1'b0;
    sink_sop = 1'b0; sink_eop = 1'b0; sink_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sink_data = 32'h100 + 32'(acc);
      took = sink_ready;
      @(posedge clk); #1;
      if (took) acc++;
    end
    sink_valid = 1'b0;
    checks++; if (acc != 14)            begin failures++; $display("FAIL bp_accepted got=%0d required=14", acc); end
    checks++; if (sink_ready !== 1'b0)  begin failures++; $display("FAIL bp_ready got=%b required=0", sink_ready); end
    checks++; if (fill_level !== 5'd14) begin failures++; $display("FAIL bp_fill got=%0d required=14", fill_level); end
    checks++; if (flow_result !== 4'b1000) begin failures++; $display("FAIL bp_outside got=%b required=1000", flow_result); end
    source_ready = 1'b1;
    while (!fifo_empty && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b required=1", fifo_empty); end
    checks++; if (q_out.size() != 14)  begin failures++; $display("FAIL drain_count got=%0d required=14", q_out.size()); end
    if (q_out.size() == 14) begin
      checks++; if (q_out[0][33:2] !== 32'h100 || q_out[13][33:2] !== 32'h10D) begin
        failures++; $display("FAIL drain_order got=%h..%h required=100..10d", q_out[0][33:2], q_out[13][33:2]);
      end
    end
    idle(1);
    checks++; if (sink_ready !== 1'b1) begin failures++; $display("FAIL drain_ready got=%b required=1", sink_ready); end
    pulse_clear();
  endtask

  task automatic test_early_eop();
    for (int i = 0; i < 5; i++) send_beat(32'hB0 + 32'(i), i == 0, i == 4);
    idle(2);
    checks++; if (flow_result !== 4'b0001) begin failures++; $display("FAIL early_eop got=%b required=0001", flow_result); end
    checks++; if (frame_count !== 16'(exp_fc)) begin failures++; $display("FAIL early_fc got=%0d required=%0d", frame_count, exp_fc); end
    pulse_clear();
    checks++; if (flow_result !== 4'b0000) begin failures++; $display("FAIL clear got=%b required=0000", flow_result); end
    err_clear = 1'b1;
    send_beat(32'hBF, 1'b0, 1'b0);
    err_clear = 1'b0;
    checks++; if (flow_result !== 4'b0000) begin failures++; $display("FAIL clear_prio got=%b required=0000", flow_result); end
  endtask

  task automatic test_missing_eop();
    for (int i = 0; i < 8; i++) send_beat(32'hC0 + 32'(i), i == 0, 1'b0);
    checks++; if (flow_result !== 4'b0010) begin failures++; $display("FAIL missing_eop got=%b required=0010", flow_result); end
    send_frame(32'hC8);
    idle(2);
    exp_fc += FC_EN;
    checks++; if (flow_result !== 4'b0010) begin failures++; $display("FAIL missing_next got=%b required=0010", flow_result); end
    checks++; if (frame_count !== 16'(exp_fc)) begin failures++; $display("FAIL missing_fc got=%0d required=%0d", frame_count, exp_fc); end
    pulse_clear();
  endtask

  task automatic test_sop_in_frame();
    send_beat(32'hD0, 1'b1, 1'b0);
    send_beat(32'hD1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_beat(32'hD2 + 32'(i), i == 0, i == 7);
    idle(2);
    exp_fc += FC_EN;
    checks++; if (flow_result !== 4'b0100) begin failures++; $display("FAIL sop_in_frame got=%b required=0100", flow_result); end
    checks++; if (frame_count !== 16'(exp_fc)) begin failures++; $display("FAIL restart_fc got=%0d required=%0d", frame_count, exp_fc); end
    pulse_clear();
  endtask

  task automatic test_mid_frame_reset();
    source_ready = 1'b0;
    send_beat(32'hE0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_beat(32'hE1 + 32'(i), i == 0, 1'b0);
    checks++; if (fill_level !== 5'd6) begin failures++; $display("FAIL pre_rst_fill got=%0d required=6", fill_level); end
    checks++; if (flow_result !== 4'b1000) begin failures++; $display("FAIL pre_rst_flow got=%b required=1000", flow_result); end
    #2 rst = 1'b1;
    #1;
    checks++; if (fill_level !== 5'd0 || source_valid !== 1'b0 || flow_result !== 4'd0) begin
      failures++; $display("FAIL mid_rst got=fill%0d/v%b/f%b required=fill0/v0/f0000", fill_level, source_valid, flow_result);
    end
    exp_fc = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    q_out.delete();
    source_ready = 1'b1;
    send_frame(32'hF0);
    idle(3);
    exp_fc += FC_EN;
    checks++; if (flow_result !== 4'd0) begin failures++; $display("FAIL post_rst_flow got=%b required=0000", flow_result); end
    checks++; if (frame_count !== 16'(exp_fc)) begin failures++; $display("FAIL post_rst_fc got=%0d required=%0d", frame_count, exp_fc); end
    checks++; if (q_out.size() != 8 || (q_out.size() > 0 && q_out[0] !== {32'hF0, 1'b1, 1'b0})) begin
      failures++; $display("FAIL post_rst_out got=%0d_beats required=8_from_f0", q_out.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    sink_data = '0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    source_ready = 1'b0; width = 16'd4; height = 16'd2; err_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_early_eop();
    test_missing_eop();
    test_sop_in_frame();
    test_mid_frame_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
